// File: rtl/cr_sysio_mtime_gen_pkg.sv
// Shared widths and types for the sysio machine-time generator.
//   MTIME_W     : width of the machine time value
//   BUS_W       : width of the software write bus
//   SYNC_STAGES : flops in the reference-tick synchroniser chain
package cr_sysio_mtime_gen_pkg;

    localparam int MTIME_W     = 64;
    localparam int BUS_W       = 32;
    localparam int SYNC_STAGES = 3;

    typedef logic [MTIME_W-1:0] mtime_t;
    typedef logic [BUS_W-1:0]   bus_t;

endpackage

// File: rtl/cr_sysio_tick_sync.sv
// Synchroniser plus rising-edge detector for an asynchronous pad strobe.
//   forever_cpuclk : core clock
//   cpurst         : synchronous active-high reset
//   async_in       : asynchronous input level
//   rise_out       : one-cycle pulse, high while the synchronised level has
//                    just gone from 0 to 1
module cr_sysio_tick_sync
    import cr_sysio_mtime_gen_pkg::*;
(
    input  logic forever_cpuclk,
    input  logic cpurst,
    input  logic async_in,
    output logic rise_out
);

    // sync_q[0] is the metastability-catching flop; edge detect uses the
    // two later stages so only settled values are compared.
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign rise_out = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cr_sysio_mtime_gen.sv
// Machine time (mtime) generator feeding the CLINT.
// Counts qualified rising edges of an asynchronous reference tick, divides
// them by DIV_RATIO and increments a 64-bit time value. Software loads the
// value with a staged low word followed by a committing high word.
//   forever_cpuclk      : core clock (only clock)
//   cpurst              : synchronous active-high reset
//   pad_sysio_ref_tick  : asynchronous reference tick
//   sysio_mtime_en      : count enable
//   had_sysio_dbg_halt  : debug halt, freezes counting
//   sysio_mtime_wr_lo   : stage wdata as the low word
//   sysio_mtime_wr_hi   : commit {wdata, staged low} to mtime
//   sysio_mtime_wdata   : write data
//   sysio_clint_mtime   : current mtime (registered)
//   sysio_mtime_tick    : one-cycle pulse after each increment
module cr_sysio_mtime_gen
    import cr_sysio_mtime_gen_pkg::*;
#(
    parameter int DIV_RATIO = 1,
    parameter int CNT_W     = 8
)
(
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               pad_sysio_ref_tick,
    input  logic               sysio_mtime_en,
    input  logic               had_sysio_dbg_halt,
    input  logic               sysio_mtime_wr_lo,
    input  logic               sysio_mtime_wr_hi,
    input  logic [BUS_W-1:0]   sysio_mtime_wdata,
    output logic [MTIME_W-1:0] sysio_clint_mtime,
    output logic               sysio_mtime_tick
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DIV_RATIO - 1);

    logic       ref_rise;
    logic       cnt_vld;
    logic       cnt_last;
    logic [CNT_W-1:0] cnt;
    bus_t       staged_lo;
    mtime_t     mtime;
    logic       tick_q;

    cr_sysio_tick_sync u_tick_sync (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .async_in       (pad_sysio_ref_tick),
        .rise_out       (ref_rise)
    );

    // Unqualified rises are simply dropped; nothing remembers them.
    assign cnt_vld  = ref_rise & sysio_mtime_en & ~had_sysio_dbg_halt;
    assign cnt_last = (cnt == CNT_TC);

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            mtime     <= '0;
            staged_lo <= '0;
            cnt       <= '0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (sysio_mtime_wr_lo) begin
                staged_lo <= sysio_mtime_wdata;
            end
            // A high-word commit overrides any increment due this cycle and
            // restarts the prescaler. A simultaneous low write is forwarded
            // so both halves take the same data.
            if (sysio_mtime_wr_hi) begin
                mtime <= {sysio_mtime_wdata,
                          sysio_mtime_wr_lo ? sysio_mtime_wdata : staged_lo};
                cnt   <= '0;
            end else if (cnt_vld) begin
                if (cnt_last) begin
                    cnt    <= '0;
                    mtime  <= mtime + MTIME_W'(1);
                    tick_q <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign sysio_clint_mtime = mtime;
    assign sysio_mtime_tick  = tick_q;

endmodule

// File: tb/tb_cr_sysio_mtime_gen.sv
module tb_cr_sysio_mtime_gen;

    localparam int RATIO_A = 1;
    localparam int RATIO_B = 4;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        pad;
    logic        en;
    logic        halt;
    logic        wr_lo;
    logic        wr_hi;
    logic [31:0] wdata;
    logic [63:0] mt_a, mt_b;
    logic        tk_a, tk_b;

    always #5 clk = ~clk;

    cr_sysio_mtime_gen #(.DIV_RATIO(RATIO_A), .CNT_W(8)) u_dut_a (
        .forever_cpuclk     (clk),
        .cpurst             (cpurst),
        .pad_sysio_ref_tick (pad),
        .sysio_mtime_en     (en),
        .had_sysio_dbg_halt (halt),
        .sysio_mtime_wr_lo  (wr_lo),
        .sysio_mtime_wr_hi  (wr_hi),
        .sysio_mtime_wdata  (wdata),
        .sysio_clint_mtime  (mt_a),
        .sysio_mtime_tick   (tk_a)
    );

    cr_sysio_mtime_gen #(.DIV_RATIO(RATIO_B), .CNT_W(8)) u_dut_b (
        .forever_cpuclk     (clk),
        .cpurst             (cpurst),
        .pad_sysio_ref_tick (pad),
        .sysio_mtime_en     (en),
        .had_sysio_dbg_halt (halt),
        .sysio_mtime_wr_lo  (wr_lo),
        .sysio_mtime_wr_hi  (wr_hi),
        .sysio_mtime_wdata  (wdata),
        .sysio_clint_mtime  (mt_b),
        .sysio_mtime_tick   (tk_b)
    );

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model: time value, qualified rises since last load/reset,
    // and the staged low word.
    logic [63:0] m_mt[2];
    int          m_rises[2];
    logic [31:0] m_staged;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ratio_of(input int d);
        return (d == 0) ? RATIO_A : RATIO_B;
    endfunction

    task automatic cmp64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input int c, input logic [63:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // A reference level first sampled at the next clock edge: the
    // increment is visible three edges after the current cycle count.
    task automatic model_rise(input int c);
        if (en && !halt) begin
            for (int d = 0; d < 2; d++) begin
                m_rises[d]++;
                if (m_rises[d] % ratio_of(d) == 0) begin
                    m_mt[d] = m_mt[d] + 64'd1;
                    push_exp(d, c + 3, m_mt[d]);
                end
            end
        end
    endtask

    task automatic mon(input int d, input logic tk, input logic [63:0] mt);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
        if (have) e = (d == 0) ? q_a[0] : q_b[0];
        if (have && e.cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tick_missing[%0d]: no tick by cycle %0d, required at cycle %0d with mtime %h",
                     d, cyc, e.cyc, e.val);
            if (d == 0) void'(q_a.pop_front());
            else        void'(q_b.pop_front());
        end else if (tk === 1'b1) begin
            if (!have) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tick_unexpected[%0d]: tick at cycle %0d mtime %h, none required", d, cyc, mt);
            end else begin
                if (d == 0) void'(q_a.pop_front());
                else        void'(q_b.pop_front());
                n_cmp++;
                if (e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL tick_cycle[%0d]: tick at cycle %0d, required at cycle %0d", d, cyc, e.cyc);
                end
                cmp64($sformatf("tick_mtime[%0d]", d), mt, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, tk_a, mt_a);
        mon(1, tk_b, mt_b);
    end

    task automatic do_reset(input int n);
        cpurst = 1'b1;
        m_mt[0] = '0;
        m_mt[1] = '0;
        m_rises[0] = 0;
        m_rises[1] = 0;
        m_staged = '0;
        q_a.delete();
        q_b.delete();
        repeat (n) @(negedge clk);
        cpurst = 1'b0;
    endtask

    task automatic pulse(input int h, input int l, input bit rnd_lo);
        pad = 1'b1;
        model_rise(cyc);
        for (int i = 0; i < h + l; i++) begin
            @(negedge clk);
            if (i == h - 1) pad = 1'b0;
            wr_lo = 1'b0;
            if (rnd_lo && i < h + l - 1 && $urandom_range(0, 3) == 0) begin
                wdata    = $urandom;
                wr_lo    = 1'b1;
                m_staged = wdata;
            end
        end
        wr_lo = 1'b0;
    endtask

    task automatic wr(input bit lo, input bit hi, input logic [31:0] d, input string name);
        wr_lo = lo;
        wr_hi = hi;
        wdata = d;
        if (lo) m_staged = d;
        if (hi) begin
            for (int k = 0; k < 2; k++) begin
                m_mt[k]    = {d, m_staged};
                m_rises[k] = 0;
            end
        end
        @(negedge clk);
        wr_lo = 1'b0;
        wr_hi = 1'b0;
        cmp64({name, "_a"}, mt_a, m_mt[0]);
        cmp64({name, "_b"}, mt_b, m_mt[1]);
        if (hi) begin
            cmp64({name, "_tick_a"}, {63'd0, tk_a}, 64'd0);
            cmp64({name, "_tick_b"}, {63'd0, tk_b}, 64'd0);
        end
    endtask

    task automatic drain_check(input string name);
        repeat (4) @(negedge clk);
        cmp64({name, "_a"}, mt_a, m_mt[0]);
        cmp64({name, "_b"}, mt_b, m_mt[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] base_a, base_b;
        cpurst = 1'b1;
        pad    = 1'b0;
        en     = 1'b0;
        halt   = 1'b0;
        wr_lo  = 1'b0;
        wr_hi  = 1'b0;
        wdata  = '0;
        @(negedge clk);
        do_reset(3);
        cmp64("reset_mtime_a", mt_a, 64'd0);
        cmp64("reset_mtime_b", mt_b, 64'd0);
        cmp64("reset_tick_a", {63'd0, tk_a}, 64'd0);
        cmp64("reset_tick_b", {63'd0, tk_b}, 64'd0);

        // Five pulses, every one counted.
        en = 1'b1;
        repeat (5) pulse(4, 4, 1'b0);
        drain_check("five_pulses");
        cmp64("five_pulses_const_a", mt_a, 64'd5);
        cmp64("five_pulses_const_b", mt_b, 64'd1);

        // Prescale by four: 10 then 2 more pulses.
        do_reset(2);
        repeat (10) pulse(4, 4, 1'b0);
        drain_check("ten_pulses");
        cmp64("ten_pulses_const_b", mt_b, 64'd2);
        repeat (2) pulse(4, 4, 1'b0);
        drain_check("twelve_pulses");
        cmp64("twelve_pulses_const_b", mt_b, 64'd3);

        // Load all ones, then wrap.
        wr(1'b1, 1'b0, 32'hFFFF_FFFF, "wr_lo_only");
        wr(1'b0, 1'b1, 32'hFFFF_FFFF, "wr_hi_ones");
        cmp64("ones_const_a", mt_a, 64'hFFFF_FFFF_FFFF_FFFF);
        pulse(4, 4, 1'b0);
        drain_check("wrap");
        cmp64("wrap_const_a", mt_a, 64'd0);

        // Debug halt and enable gating; writes still honoured while halted.
        base_a = m_mt[0];
        halt = 1'b1;
        repeat (3) pulse(4, 4, 1'b0);
        halt = 1'b0;
        repeat (2) pulse(4, 4, 1'b0);
        drain_check("halt");
        cmp64("halt_plus2_a", mt_a, base_a + 64'd2);
        base_a = m_mt[0];
        en = 1'b0;
        repeat (3) pulse(4, 4, 1'b0);
        en = 1'b1;
        repeat (2) pulse(4, 4, 1'b0);
        drain_check("disable");
        cmp64("disable_plus2_a", mt_a, base_a + 64'd2);
        halt = 1'b1;
        wr(1'b0, 1'b1, 32'h0000_0001, "wr_halted");
        halt = 1'b0;

        // High-word commit collides with a due increment.
        wr(1'b1, 1'b0, 32'h0000_0034, "stage_34");
        pad = 1'b1;
        repeat (2) @(negedge clk);
        wr(1'b0, 1'b1, 32'h0000_0012, "collide");
        pad = 1'b0;
        repeat (4) @(negedge clk);
        cmp64("collide_const_a", mt_a, 64'h0000_0012_0000_0034);
        cmp64("collide_const_b", mt_b, 64'h0000_0012_0000_0034);
        repeat (4) pulse(3, 3, 1'b0);
        drain_check("after_collide");
        cmp64("after_collide_b", mt_b, 64'h0000_0012_0000_0035);

        wr(1'b1, 1'b1, 32'hA5A5_5A5A, "wr_both");
        cmp64("wr_both_const_a", mt_a, 64'hA5A5_5A5A_A5A5_5A5A);

        // Reference held high through reset gives exactly one rise.
        pad = 1'b1;
        do_reset(3);
        model_rise(cyc);
        repeat (6) @(negedge clk);
        pad = 1'b0;
        drain_check("held_high");
        cmp64("held_high_const_a", mt_a, 64'd1);
        cmp64("held_high_const_b", mt_b, 64'd0);

        // Reset in the middle of counting, with an edge in the synchroniser.
        wr(1'b1, 1'b0, 32'd6, "stage_6");
        wr(1'b0, 1'b1, 32'd0, "load_6");
        pulse(4, 4, 1'b0);
        drain_check("seven");
        cmp64("seven_const_a", mt_a, 64'd7);
        pad = 1'b1;
        @(negedge clk);
        pad = 1'b0;
        do_reset(1);
        cmp64("midreset_a", mt_a, 64'd0);
        cmp64("midreset_b", mt_b, 64'd0);
        drain_check("midreset_quiet");

        // Randomised pulses, gating, and writes.
        do_reset(2);
        for (int it = 0; it < 80; it++) begin
            en   = ($urandom_range(0, 3) != 0);
            halt = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) begin
                logic [31:0] d;
                bit lo, hi;
                d  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                lo = ($urandom_range(0, 1) == 1);
                hi = ($urandom_range(0, 2) != 0);
                wr(lo, hi, d, "rnd_wr");
            end
            pulse($urandom_range(1, 4), $urandom_range(2, 5), 1'b1);
        end
        drain_check("random_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
